// File: rtl/load_store_unit.sv
// load_store_unit: connects the core's byte-addressed load/store requests
// to a word-organised data memory. Loads are sign- or zero-extended. Sub-word
// stores are done as a read-modify-write and cost one stall cycle.
// Misaligned and invalid requests are suppressed. Misaligned requests also
// set a sticky flag.
//
// Handshake: there is no valid/ready pair. A request is MemWrite or MemRead
// being high. While Stall is high, the core holds Adr, StoreData, Funct3,
// MemWrite and MemRead stable. The request retires on the first rising edge
// at which Stall is low.
module load_store_unit #(
    parameter int width = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] Adr,
    input  logic [width-1:0] StoreData,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [2:0]       Funct3,
    output logic [width-1:0] LoadData,
    output logic             Stall,
    output logic             Misaligned,
    output logic             MisalignedSticky,
    output logic [width-1:0] MemAdr,
    output logic [width-1:0] MemWData,
    output logic             MemWE,
    input  logic [width-1:0] MemRData,
    output logic             o_dbg_state,
    output logic [width-1:0] o_dbg_word_q
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t           r_state;
    logic [width-1:0] r_word_q;
    logic             r_sticky;

    logic             w_f3_valid;
    logic             w_size_b;
    logic             w_size_h;
    logic             w_size_w;
    logic             w_req;
    logic             w_misaligned;
    logic             w_ok;
    logic             w_store_ok;
    logic             w_load_ok;
    logic             w_sub_store;
    logic             w_word_store;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [width-1:0] w_merged;

    // Decode Funct3 into an access size and check that the encoding is legal.
    always_comb begin
        w_f3_valid = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_valid = 1'b1;
            default:                                w_f3_valid = 1'b0;
        endcase
    end

    assign w_size_b     = (Funct3[1:0] == 2'b00);
    assign w_size_h     = (Funct3[1:0] == 2'b01);
    assign w_size_w     = (Funct3[1:0] == 2'b10);
    assign w_req        = MemWrite | MemRead;
    assign w_misaligned = w_req & w_f3_valid &
                          ((w_size_h & Adr[0]) | (w_size_w & (Adr[1:0] != 2'b00)));
    assign w_ok         = w_req & w_f3_valid & ~w_misaligned;
    // A store has priority when both request lines are high.
    assign w_store_ok   = MemWrite & w_ok;
    assign w_load_ok    = MemRead & ~MemWrite & w_ok;
    assign w_sub_store  = w_store_ok & ~w_size_w;
    assign w_word_store = w_store_ok & w_size_w;

    assign Misaligned       = w_misaligned;
    assign MisalignedSticky = r_sticky;
    assign MemAdr           = {Adr[width-1:2], 2'b00};
    assign Stall            = ~RST & (r_state == S_IDLE) & w_sub_store;
    assign MemWE            = ~RST & ((r_state == S_WRITE) |
                                      ((r_state == S_IDLE) & w_word_store));
    assign MemWData         = (r_state == S_WRITE) ? w_merged : StoreData;
    assign o_dbg_state      = r_state;
    assign o_dbg_word_q     = r_word_q;

    // Select the addressed byte and halfword lanes of the memory word.
    always_comb begin
        w_byte = 8'h00;
        case (Adr[1:0])
            2'b00:   w_byte = MemRData[7:0];
            2'b01:   w_byte = MemRData[15:8];
            2'b10:   w_byte = MemRData[23:16];
            default: w_byte = MemRData[31:24];
        endcase
        w_half = Adr[1] ? MemRData[31:16] : MemRData[15:0];
    end

    // Extend the selected lane. Suppressed or absent loads return zero.
    always_comb begin
        LoadData = '0;
        if (w_load_ok) begin
            case (Funct3)
                3'b000:  LoadData = {{(width-8){w_byte[7]}}, w_byte};
                3'b100:  LoadData = {{(width-8){1'b0}}, w_byte};
                3'b001:  LoadData = {{(width-16){w_half[15]}}, w_half};
                3'b101:  LoadData = {{(width-16){1'b0}}, w_half};
                3'b010:  LoadData = MemRData;
                default: LoadData = '0;
            endcase
        end
    end

    // Replace the addressed lane(s) of the captured word with store data.
    // Adr and Funct3 are held by the core during the stall.
    always_comb begin
        w_merged = r_word_q;
        if (w_size_b) begin
            case (Adr[1:0])
                2'b00:   w_merged[7:0]   = StoreData[7:0];
                2'b01:   w_merged[15:8]  = StoreData[7:0];
                2'b10:   w_merged[23:16] = StoreData[7:0];
                default: w_merged[31:24] = StoreData[7:0];
            endcase
        end else begin
            if (Adr[1]) w_merged[31:16] = StoreData[15:0];
            else        w_merged[15:0]  = StoreData[15:0];
        end
    end

    // Read-modify-write sequencer and sticky misalignment flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_word_q <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= r_sticky | w_misaligned;
            case (r_state)
                S_IDLE: begin
                    if (w_sub_store) begin
                        r_word_q <= MemRData;
                        r_state  <= S_WRITE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
